add32_seq_ctrl: RTL and testbench
=================================

Name: add32_seq_ctrl

Overview:
Sequencer that performs a 32-bit add over one shared 16-bit clocked adder (ports a, d, carryin → p, carryout). Takes a 32-bit operand pair plus carry-in via valid/ready handshake, issues the low-half then high-half add to the adder, chains the low-half carry into the high half, and returns the 32-bit sum and carry-out via valid/ready. Sits between the operand source and the 16-bit adder instance; the adder is driven only by this block.

Parameters:
ADD_LAT, 1, cycles from adder input drive to valid p/carryout (legal 0..7; 0 = combinational adder)
HW, 16, adder half width; full operand width is 2*HW

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
in_a  input  2*HW  operand A
in_b  input  2*HW  operand B
in_cin  input  1  carry-in of the 32-bit add
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_sum  output  2*HW  sum, modulo 2^(2*HW)
out_cout  output  1  carry-out of bit 2*HW-1
busy  output  1  high in any state but IDLE
add_a  output  HW  to adder a
add_d  output  HW  to adder d
add_cin  output  1  to adder carryin
add_p  input  HW  from adder p
add_cout  input  1  from adder carryout

Behaviour:
- States: IDLE, LO, HI, DONE (registered state, binary encoding).
- Reset (rst high at edge): state IDLE; out_valid, out_sum, out_cout, add_a, add_d, add_cin, busy all 0; operand regs and wait counter cleared. in_ready = (state==IDLE) & ~rst, so in_ready is 0 while rst is high.
- IDLE: in_ready=1. On in_valid & in_ready at edge E0: register in_a, in_b, in_cin; go to LO; clear counter.
- LO: add_a=A[HW-1:0], add_d=B[HW-1:0], add_cin=cin, all held constant. Lasts exactly ADD_LAT+1 cycles. At the final edge of LO: capture add_p → sum_lo and add_cout → c_lo; go to HI.
- HI: add_a=A[2HW-1:HW], add_d=B[2HW-1:HW], add_cin=c_lo. Lasts ADD_LAT+1 cycles. At the final edge: capture add_p → out_sum[2HW-1:HW], add_cout → out_cout, sum_lo → out_sum[HW-1:0]; go to DONE.
- DONE: out_valid=1; out_sum/out_cout stable until handshake. On out_valid & out_ready: go to IDLE, out_valid deasserts next cycle.
- Latency: out_valid first high 2*(ADD_LAT+1) cycles after E0 (4 cycles for ADD_LAT=1). Throughput: one op per 2*(ADD_LAT+1)+2 cycles when out_ready is held high.
- In IDLE and DONE, add_a/add_d/add_cin are driven to 0.
- in_valid outside IDLE is ignored; the request stays pending at the source.
- Unsigned arithmetic; {out_cout,out_sum} = in_a + in_b + in_cin exactly.
- Reset mid-operation (any state): next edge returns to IDLE, partial result discarded, out_valid stays 0, no result emitted for that request.
- Wait counter is 3 bits and saturates at the terminal count; it never wraps inside a state.

Test Plan:
- ADD_LAT=1, a=510, b=60, cin=0 → out_sum=570, out_cout=0; out_valid exactly 4 cycles after accept edge; add_cin=0 during HI.
- a=0x0000FFFF, b=0x00000001, cin=0 → LO gives add_p=0x0000, add_cout=1; HI drives add_cin=1; out_sum=0x00010000, out_cout=0.
- a=0xFFFFFFFF, b=0x00000000, cin=1 → out_sum=0x00000000, out_cout=1. Also a=1500, b=1160 → 2660, cout 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands → out_sum/out_cout unchanged, in_ready=0, new request accepted only in the cycle after the out handshake.
- Reset during HI: assert rst for 1 cycle → next cycle state IDLE, out_valid=0, add_* =0, in_ready=1 after rst drops; subsequent 30+600 → 630.
- ADD_LAT=3 rebuild: random 200 operand pairs vs reference model → all match; out_valid 8 cycles after each accept.

Source files
------------

// File: rtl/add32_seq_ctrl.sv
// Sequences a 2*HW-bit add as low half then high half over one shared HW-bit
// clocked adder, chaining the low-half carry into the high half.
module add32_seq_ctrl #(
  parameter int ADD_LAT = 1,
  parameter int HW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*HW-1:0] in_a,
  input  logic [2*HW-1:0] in_b,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*HW-1:0] out_sum,
  output logic            out_cout,
  output logic            busy,
  output logic [HW-1:0]   add_a,
  output logic [HW-1:0]   add_d,
  output logic            add_cin,
  input  logic [HW-1:0]   add_p,
  input  logic            add_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] TERM = 3'(ADD_LAT);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2*HW-1:0] a_q, b_q;
  logic            cin_q;
  logic [HW-1:0]   sum_lo_q;
  logic            c_lo_q;
  logic [2*HW-1:0] sum_q;
  logic            cout_q;
  logic            last, accept, out_hs;

  // Each half holds the adder inputs for ADD_LAT+1 cycles; the last edge sees p.
  assign last   = (cnt_q == TERM);
  assign accept = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LO;
      S_LO:   if (last)   state_d = S_HI;
      S_HI:   if (last)   state_d = S_DONE;
      S_DONE: if (out_hs) state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~rst;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    add_a     = '0;
    add_d     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      S_LO: begin
        add_a   = a_q[HW-1:0];
        add_d   = b_q[HW-1:0];
        add_cin = cin_q;
      end
      S_HI: begin
        add_a   = a_q[2*HW-1:HW];
        add_d   = b_q[2*HW-1:HW];
        add_cin = c_lo_q;
      end
      default: ;
    endcase
  end

  // Counter restarts on every state change and saturates at the terminal count.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (last) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sum_lo_q <= '0;
      c_lo_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        cin_q <= in_cin;
      end
      if (state_q == S_LO && last) begin
        sum_lo_q <= add_p;
        c_lo_q   <= add_cout;
      end
      if (state_q == S_HI && last) begin
        sum_q  <= {add_p, sum_lo_q};
        cout_q <= add_cout;
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Two sequencers (adder latency 1 and 3) each paired with a pipelined adder model;
// an abstract per-lane model predicts every output each cycle, directed ops pin literals.
module tb_add32_seq_ctrl;

  localparam int HW = 16;

  logic          clk;
  logic          rst       [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [31:0]   in_a      [2];
  logic [31:0]   in_b      [2];
  logic          in_cin    [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [31:0]   out_sum   [2];
  logic          out_cout  [2];
  logic          busy      [2];
  logic [HW-1:0] add_a     [2];
  logic [HW-1:0] add_d     [2];
  logic          add_cin   [2];
  logic [HW-1:0] add_p     [2];
  logic          add_cout  [2];

  int checks   = 0;
  int failures = 0;
  bit en       = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [HW:0] pipe [8];
    always_ff @(posedge clk) begin
      pipe[0] <= {1'b0, add_a[g]} + {1'b0, add_d[g]} + 17'(add_cin[g]);
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign {add_cout[g], add_p[g]} = pipe[LAT-1];

    add32_seq_ctrl #(.ADD_LAT(LAT), .HW(HW)) dut (
      .clk(clk), .rst(rst[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]), .in_cin(in_cin[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_sum(out_sum[g]), .out_cout(out_cout[g]), .busy(busy[g]),
      .add_a(add_a[g]), .add_d(add_d[g]), .add_cin(add_cin[g]),
      .add_p(add_p[g]), .add_cout(add_cout[g])
    );

    // Model: an op occupies cycles acc.. ; phase d = cycle - acc picks low half,
    // high half, then result-held, purely from the add latency.
    int          cyc = 0;
    int          acc = 0;
    bit          outst = 1'b0;
    logic [31:0] op_a, op_b;
    logic        op_c;

    always begin
      int          d;
      bit          ev;
      logic [32:0] full;
      logic [16:0] lo;
      logic [15:0] ea, ed;
      logic        ec;
      @(negedge clk);
      #2;
      if (en) begin
        d    = cyc - acc;
        ev   = outst && (d >= 2 * LAT + 2);
        full = {1'b0, op_a} + {1'b0, op_b} + 33'(op_c);
        lo   = {1'b0, op_a[15:0]} + {1'b0, op_b[15:0]} + 17'(op_c);
        ea = '0; ed = '0; ec = 1'b0;
        if (outst && !ev) begin
          if (d <= LAT) begin
            ea = op_a[15:0];  ed = op_b[15:0];  ec = op_c;
          end else begin
            ea = op_a[31:16]; ed = op_b[31:16]; ec = lo[16];
          end
        end
        check($sformatf("L%0d in_ready", g), 64'(in_ready[g]), 64'(!outst && !rst[g]));
        check($sformatf("L%0d busy", g), 64'(busy[g]), 64'(outst));
        check($sformatf("L%0d out_valid", g), 64'(out_valid[g]), 64'(ev));
        check($sformatf("L%0d add_a", g), 64'(add_a[g]), 64'(ea));
        check($sformatf("L%0d add_d", g), 64'(add_d[g]), 64'(ed));
        check($sformatf("L%0d add_cin", g), 64'(add_cin[g]), 64'(ec));
        if (ev) begin
          check($sformatf("L%0d out_sum", g), 64'(out_sum[g]), 64'(full[31:0]));
          check($sformatf("L%0d out_cout", g), 64'(out_cout[g]), 64'(full[32]));
        end
        if (rst[g]) begin
          outst = 1'b0;
        end else if (!outst && in_valid[g]) begin
          outst = 1'b1;
          acc   = cyc + 1;
          op_a  = in_a[g];
          op_b  = in_b[g];
          op_c  = in_cin[g];
        end else if (ev && out_ready[g]) begin
          outst = 1'b0;
        end
      end
      cyc++;
    end
  end

  task automatic do_op(input int ln, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [31:0] es, input logic ec);
    int n;
    @(negedge clk);
    in_a[ln] = a; in_b[ln] = b; in_cin[ln] = c; in_valid[ln] = 1'b1;
    n = 0;
    while (!in_ready[ln] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      timeout("accept wait");
      in_valid[ln] = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid[ln] = 1'b0;
    n = 0;
    while (!out_valid[ln] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      timeout("result wait");
      return;
    end
    check($sformatf("L%0d lit sum", ln), 64'(out_sum[ln]), 64'(es));
    check($sformatf("L%0d lit cout", ln), 64'(out_cout[ln]), 64'(ec));
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] rs;
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; in_valid[l] = 1'b0; out_ready[l] = 1'b1;
      in_a[l] = '0; in_b[l] = '0; in_cin[l] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready[0]), 64'd0);
    rst[0] = 1'b0; rst[1] = 1'b0; en = 1'b1;
    @(negedge clk);
    check("rst out_valid", 64'(out_valid[0]), 64'd0);
    check("rst out_sum", 64'(out_sum[0]), 64'd0);
    check("rst busy", 64'(busy[1]), 64'd0);
    check("rst add_a", 64'(add_a[1]), 64'd0);
    check("post-rst in_ready", 64'(in_ready[0]), 64'd1);

    do_op(0, 32'd510, 32'd60, 1'b0, 32'd570, 1'b0);
    do_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0);
    do_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1);
    do_op(0, 32'd1500, 32'd1160, 1'b0, 32'd2660, 1'b0);

    // Backpressure: result must hold and no new op may enter while DONE stalls.
    out_ready[0] = 1'b0;
    do_op(0, 32'd100, 32'd200, 1'b0, 32'd300, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = i[0]; in_a[0] = 32'(i * 11); in_b[0] = 32'(i);
      @(negedge clk);
      check("bp sum", 64'(out_sum[0]), 64'd300);
      check("bp in_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 1'b1; in_a[0] = 32'd7; in_b[0] = 32'd8; in_cin[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp after hs out_valid", 64'(out_valid[0]), 64'd0);
    check("bp after hs in_ready", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("bp result wait");
    else check("bp next sum", 64'(out_sum[0]), 64'd15);
    @(negedge clk);

    // Reset landing in the high-half phase drops the op entirely.
    in_a[0] = 32'd5; in_b[0] = 32'd6; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-rst busy", 64'(busy[0]), 64'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("mid-rst out_valid", 64'(out_valid[0]), 64'd0);
    check("mid-rst add_a", 64'(add_a[0]), 64'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("after rst in_ready", 64'(in_ready[0]), 64'd1);
    check("after rst busy", 64'(busy[0]), 64'd0);
    do_op(0, 32'd30, 32'd600, 1'b0, 32'd630, 1'b0);

    do_op(1, 32'd510, 32'd60, 1'b0, 32'd570, 1'b0);
    do_op(1, 32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010001, 1'b0);
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1));
      if (i < 4) begin
        ra = 32'hFFFF0000 | ra; rb = 32'h0000FFFF | rb;
      end
      rs = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      do_op(1, ra, rb, rc, rs[31:0], rs[32]);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
